// File: rtl/uart_autobaud_if.sv
// Serial and byte-side signals of the autobauding UART.
// The slave side is the UART itself; the master side drives it.
interface uart_autobaud_if;
   logic       rxd;
   logic       txd;
   logic       dix;
   logic [7:0] id;
   logic       dox;
   logic [7:0] od;
   logic       cal;
   logic       ferr;
   logic       ovr;

   modport slave (
      input  rxd, dox, od,
      output txd, dix, id, cal, ferr, ovr
   );

   modport master (
      output rxd, dox, od,
      input  txd, dix, id, cal, ferr, ovr
   );
endinterface

// File: rtl/uart_autobaud.sv
// UART that learns its bit period from the start bit of an 'a'/'i' byte.
// The receiver and the transmitter share only the measured bit period.
module uart_autobaud #(
   parameter int DIVW   = 16,
   parameter int MINDIV = 4
) (
   input logic           clk,
   input logic           nreset,
   uart_autobaud_if.slave u
);
   typedef enum logic [2:0] {UNCAL, MEAS, IDLE, DATA, STOP} rx_st_e;

   localparam logic [DIVW-1:0] CMAX = '1;
   localparam logic [DIVW-1:0] C1   = DIVW'(1);
   localparam logic [DIVW-1:0] CMIN = DIVW'(MINDIV);
   localparam logic [DIVW:0]   W1   = (DIVW+1)'(1);

   logic s1_q, rs_q, rsd_q;
   rx_st_e st_q, st_d;
   logic [DIVW-1:0] cnt_q, cnt_d;
   logic [DIVW-1:0] t_q, t_d;
   logic [DIVW:0] tmr_q, tmr_d;
   logic [2:0] bitn_q, bitn_d;
   logic strt_q, strt_d;
   logic [7:0] sh_q, sh_d;
   logic [7:0] id_q, id_d;
   logic dix_q, dix_d;
   logic ferr_q, ferr_d;
   logic cal_q, cal_d;

   logic tbusy_q, tbusy_d;
   logic [DIVW-1:0] tcnt_q, tcnt_d;
   logic [DIVW-1:0] tt_q, tt_d;
   logic [3:0] tbit_q, tbit_d;
   logic [7:0] tdat_q, tdat_d;
   logic txd_q, txd_d;
   logic hv_q, hv_d;
   logic [7:0] hold_q, hold_d;
   logic ovr_q, ovr_d;

   logic fall, tz, done, free, start;
   logic [DIVW:0] cx, tx1;
   logic [7:0] sbyte;

   assign fall = rsd_q & ~rs_q;
   assign tz   = (tmr_q == '0);
   assign cx   = {1'b0, cnt_q};
   assign tx1  = {1'b0, t_q};

   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      t_d    = t_q;
      tmr_d  = tmr_q;
      bitn_d = bitn_q;
      strt_d = strt_q;
      sh_d   = sh_q;
      id_d   = id_q;
      cal_d  = cal_q;
      dix_d  = 1'b0;
      ferr_d = 1'b0;
      unique case (st_q)
         UNCAL: begin
            if (fall) begin
               st_d  = MEAS;
               cnt_d = C1;
            end
         end
         MEAS: begin
            if (rs_q) begin
               if (cnt_q != CMAX && cnt_q >= CMIN) begin
                  // Line is now in bit0, which must be 1.
                  t_d    = cnt_q;
                  cal_d  = 1'b1;
                  sh_d   = 8'h80;
                  bitn_d = 3'd1;
                  strt_d = 1'b0;
                  tmr_d  = (cx >> 1) + cx - W1;
                  st_d   = DATA;
               end else begin
                  st_d = UNCAL;
               end
            end else if (cnt_q != CMAX) begin
               cnt_d = cnt_q + C1;
            end
         end
         IDLE: begin
            if (fall) begin
               st_d   = DATA;
               strt_d = 1'b1;
               tmr_d  = (tx1 >> 1) - W1;
            end
         end
         DATA: begin
            if (!tz) begin
               tmr_d = tmr_q - W1;
            end else if (strt_q) begin
               if (rs_q) begin
                  st_d = IDLE;
               end else begin
                  strt_d = 1'b0;
                  bitn_d = 3'd0;
                  tmr_d  = tx1 - W1;
               end
            end else begin
               sh_d  = {rs_q, sh_q[7:1]};
               tmr_d = tx1 - W1;
               if (bitn_q == 3'd7) st_d = STOP;
               else bitn_d = bitn_q + 3'd1;
            end
         end
         STOP: begin
            if (!tz) begin
               tmr_d = tmr_q - W1;
            end else if (rs_q) begin
               id_d  = sh_q;
               dix_d = 1'b1;
               st_d  = IDLE;
            end else begin
               // A low line that stays low is ignored until it rises.
               ferr_d = 1'b1;
               if (sh_q == 8'h00) begin
                  cal_d = 1'b0;
                  st_d  = UNCAL;
               end else begin
                  st_d = IDLE;
               end
            end
         end
         default: st_d = UNCAL;
      endcase
   end

   assign done = tbusy_q && tcnt_q == '0 && tbit_q == 4'd9;
   assign free = !tbusy_q || done;

   always_comb begin
      tbusy_d = tbusy_q;
      tcnt_d  = tcnt_q;
      tt_d    = tt_q;
      tbit_d  = tbit_q;
      tdat_d  = tdat_q;
      txd_d   = txd_q;
      hv_d    = hv_q;
      hold_d  = hold_q;
      ovr_d   = 1'b0;
      start   = 1'b0;
      sbyte   = 8'h00;
      if (tbusy_q && !done) begin
         if (tcnt_q == '0) begin
            tcnt_d = tt_q - C1;
            tbit_d = tbit_q + 4'd1;
            if (tbit_q == 4'd8) begin
               txd_d = 1'b1;
            end else begin
               txd_d  = tdat_q[0];
               tdat_d = tdat_q >> 1;
            end
         end else begin
            tcnt_d = tcnt_q - C1;
         end
      end
      if (done) begin
         tbusy_d = 1'b0;
         txd_d   = 1'b1;
      end
      if (free && hv_q && cal_q) begin
         start = 1'b1;
         sbyte = hold_q;
         hv_d  = 1'b0;
      end
      if (u.dox) begin
         if (!cal_q) begin
            ovr_d = 1'b1;
         end else if (free && !hv_q) begin
            start = 1'b1;
            sbyte = u.od;
         end else if (!hv_q) begin
            hv_d   = 1'b1;
            hold_d = u.od;
         end else begin
            ovr_d = 1'b1;
         end
      end
      // The running frame keeps tt_q; only the queued byte is lost.
      if (!cal_q) hv_d = 1'b0;
      if (start) begin
         tbusy_d = 1'b1;
         txd_d   = 1'b0;
         tcnt_d  = t_q - C1;
         tt_d    = t_q;
         tbit_d  = 4'd0;
         tdat_d  = sbyte;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         s1_q    <= 1'b1;
         rs_q    <= 1'b1;
         rsd_q   <= 1'b1;
         st_q    <= UNCAL;
         cnt_q   <= '0;
         t_q     <= '0;
         tmr_q   <= '0;
         bitn_q  <= 3'd0;
         strt_q  <= 1'b0;
         sh_q    <= 8'h00;
         id_q    <= 8'h00;
         dix_q   <= 1'b0;
         ferr_q  <= 1'b0;
         cal_q   <= 1'b0;
         tbusy_q <= 1'b0;
         tcnt_q  <= '0;
         tt_q    <= '0;
         tbit_q  <= 4'd0;
         tdat_q  <= 8'h00;
         txd_q   <= 1'b1;
         hv_q    <= 1'b0;
         hold_q  <= 8'h00;
         ovr_q   <= 1'b0;
      end else begin
         s1_q    <= u.rxd;
         rs_q    <= s1_q;
         rsd_q   <= rs_q;
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         t_q     <= t_d;
         tmr_q   <= tmr_d;
         bitn_q  <= bitn_d;
         strt_q  <= strt_d;
         sh_q    <= sh_d;
         id_q    <= id_d;
         dix_q   <= dix_d;
         ferr_q  <= ferr_d;
         cal_q   <= cal_d;
         tbusy_q <= tbusy_d;
         tcnt_q  <= tcnt_d;
         tt_q    <= tt_d;
         tbit_q  <= tbit_d;
         tdat_q  <= tdat_d;
         txd_q   <= txd_d;
         hv_q    <= hv_d;
         hold_q  <= hold_d;
         ovr_q   <= ovr_d;
      end
   end

   assign u.txd  = txd_q;
   assign u.dix  = dix_q;
   assign u.id   = id_q;
   assign u.cal  = cal_q;
   assign u.ferr = ferr_q;
   assign u.ovr  = ovr_q;
endmodule

// File: doc/uart_autobaud.md
UART_AUTOBAUD -- requirements
Module: uart_autobaud

Interface
REQ-001 The block SHALL have parameter DIVW, default 16: width of the bit-period divisor and the bit-period counters.
REQ-002 The block SHALL have parameter MINDIV, default 4: the smallest bit period, in clocks, that is accepted as a valid calibration.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port nreset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port rxd, input, 1 bit: serial receive line, asynchronous to clk, idle high.
REQ-006 The block SHALL have port txd, output, 1 bit: serial transmit line, idle high.
REQ-007 The block SHALL have port dix, output, 1 bit: one-cycle pulse that marks a valid received byte on id.
REQ-008 The block SHALL have port id, output, 8 bits: the last received byte, held stable until the next dix.
REQ-009 The block SHALL have port dox, input, 1 bit: one-cycle request to transmit od.
REQ-010 The block SHALL have port od, input, 8 bits: the byte to transmit, sampled in the cycle where dox=1.
REQ-011 The block SHALL have port cal, output, 1 bit: high when a valid bit period is held.
REQ-012 The block SHALL have port ferr, output, 1 bit: one-cycle pulse on a framing error.
REQ-013 The block SHALL have port ovr, output, 1 bit: one-cycle pulse when a transmit request is dropped.

Function
REQ-014 rxd SHALL pass through a 2-flop synchroniser; every receive timing rule below refers to the synchronised signal rs.
REQ-015 The receive FSM SHALL have the states UNCAL, MEAS, IDLE, DATA and STOP.
REQ-016 In UNCAL, a falling edge of rs SHALL enter MEAS and clear the measurement counter.
REQ-017 MEAS SHALL count clocks while rs=0; on the rising edge, T = count (the start-bit width).
REQ-018 If T >= MINDIV, the block SHALL store T, set cal=1 and take bit0=1, since the first byte must be 'a' or 'i'.
REQ-019 After a valid measurement the FSM SHALL enter DATA, with the next sample floor(T/2)+T clocks after the rising edge (bit1).
REQ-020 If T < MINDIV, the block SHALL treat the pulse as a glitch, return to UNCAL and produce no dix.
REQ-021 If the measurement counter reaches 2^DIVW-1, it SHALL saturate; the block SHALL return to UNCAL once rs rises, with no dix.
REQ-022 In IDLE, a falling edge SHALL start a frame, and the start bit SHALL be re-sampled floor(T/2) clocks later.
REQ-023 If the start-bit re-sample reads 1, the block SHALL treat it as a glitch and return to IDLE with no output.
REQ-024 Data bits SHALL be sampled every T clocks, LSB first, 8 bits.
REQ-025 The stop bit SHALL be sampled T clocks after bit7.
REQ-026 A stop bit of 1 SHALL update id and pulse dix for exactly one cycle at the stop-sample clock, then go to IDLE.
REQ-027 The first byte, the calibration byte, SHALL be delivered on dix like any other byte.
REQ-028 A stop bit of 0 SHALL pulse ferr, leave id unchanged, produce no dix, and go to IDLE once rs=1.
REQ-029 A stop bit of 0 with all data bits 0 is a break: the block SHALL also clear cal and go to UNCAL after rs returns high.
REQ-030 The transmitter SHALL consist of a shift register plus a one-byte holding register, with bit period T.
REQ-031 If dox=1 and the shifter is idle, transmission SHALL start next cycle: start 0, 8 data bits LSB first, stop 1, each exactly T clocks.
REQ-032 If dox=1 while the shifter is busy and the holding register is empty, od SHALL be held and sent immediately after the current stop bit, with no idle gap.
REQ-033 If dox=1 while both the shifter and the holding register are full, the request SHALL be dropped and ovr pulsed.
REQ-034 If dox=1 while cal=0, the request SHALL be dropped and ovr pulsed.
REQ-035 If cal drops during a transmission, the current frame SHALL complete with the old T; the holding register SHALL be discarded.
REQ-036 Simultaneous dix and dox events SHALL be independent; receive and transmit SHALL share only T.

Reset
REQ-037 While nreset=0: txd=1, dix=0, id=0, cal=0, ferr=0, ovr=0, T=0, both FSMs idle/UNCAL, holding register empty.
REQ-038 Reset mid-frame, on either direction, SHALL abort immediately, with txd=1 in the same cycle.
REQ-039 After reset, the first falling edge of rs SHALL be treated as a calibration start.

Verification
REQ-040 The bench SHALL send 'i' (0x69) at 16 clk/bit after reset -> cal=1, T=16, one dix pulse with id=0x69 at mid-stop (about 152 clk after the start edge plus sync delay).
REQ-041 The bench SHALL then send 'a' (0x61) followed by 0x12 and 0x34 -> three dix pulses with id 0x61, 0x12, 0x34; no ferr.
REQ-042 The bench SHALL pulse dox with od=0x5A -> txd low 16 clk, then bits 0,1,0,1,1,0,1,0 at 16 clk each, then high 16 clk.
REQ-043 The bench SHALL pulse dox three times, one cycle apart, with 0x01, 0x02 and 0x03 -> 0x01 and 0x02 sent back-to-back; ovr pulses once, for 0x03.
REQ-044 The bench SHALL drive a 2-clk low glitch before calibration -> cal stays 0, no dix; the bench SHALL also send a 0x00 frame with stop=0 -> ferr pulse, cal=0, and the next 'i' at 32 clk/bit recalibrates to T=32.
REQ-045 The bench SHALL assert nreset during bit3 of a transmit -> txd=1 immediately, cal=0, and no residual frame after release.
